// File: rtl/timer.sv
//------------------------------------------------------------------------------
// timer
//------------------------------------------------------------------------------
// General-purpose up-counting timer with a clock prescaler, programmable
// auto-reload (terminal count), periodic and one-shot modes, a wrapping
// event counter and an interrupt output.
//
// Ports:
//   clk              system clock, all logic on the rising edge
//   rst              asynchronous active-low reset, clears all state
//   prescaler        one count tick every prescaler+1 enabled clocks
//   autoreload       terminal count value (compared with >=)
//   timer_clear      synchronous clear of prescaler, count, event, done, irq
//   timer_enable     1 = run, 0 = freeze all state
//   timer_mode       1 = periodic (auto-reload), 0 = one-shot
//   timer_event      terminal-count events since reset/clear (wraps)
//   timer_count      current counter value
//   timer_interrupt  one-clock pulse per terminal-count event
//
// Configuration macro:
//   TIMER_IRQ_STICKY_EN  when defined, timer_interrupt is a sticky flag that
//                        sets on each terminal-count event and stays set until
//                        timer_clear or reset (clear wins over a same-cycle set).
//
// prescaler, autoreload and timer_mode are used live every clock; there are
// no shadow registers, so reprogramming takes effect on the next tick.
//------------------------------------------------------------------------------
`default_nettype none

module timer #(
   parameter int PSC_W = 8,
   parameter int CNT_W = 32,
   parameter int EVT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PSC_W-1:0] prescaler,
   input  logic [CNT_W-1:0] autoreload,
   input  logic             timer_clear,
   input  logic             timer_enable,
   input  logic             timer_mode,
   output logic [EVT_W-1:0] timer_event,
   output logic [CNT_W-1:0] timer_count,
   output logic             timer_interrupt
);

   // State registers
   logic [PSC_W-1:0] r_psc_cnt;
   logic [CNT_W-1:0] r_count;
   logic [EVT_W-1:0] r_event;
   logic             r_done;
   logic             r_irq;

   // Combinational next-state and decode
   logic             w_tick;
   logic             w_at_term;
   logic             w_fire;
   logic [PSC_W-1:0] w_psc_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [EVT_W-1:0] w_evt_nxt;
   logic             w_done_nxt;
   logic             w_irq_nxt;

   // Terminal condition uses >= so a lowered autoreload takes effect on the next tick
   assign w_at_term = (r_count >= autoreload);

   // Prescaler tick: only while running and not being cleared
   always_comb begin
      w_tick = 1'b0;
      if (timer_enable && !timer_clear && (r_psc_cnt >= prescaler)) begin
         w_tick = 1'b1;
      end else begin
         w_tick = 1'b0;
      end
   end

   // Terminal-count event: a periodic wrap, or the first termination of a one-shot run
   always_comb begin
      w_fire = 1'b0;
      if (w_tick && w_at_term) begin
         if (timer_mode) begin
            w_fire = 1'b1;
         end else if (!r_done) begin
            w_fire = 1'b1;
         end else begin
            w_fire = 1'b0;
         end
      end else begin
         w_fire = 1'b0;
      end
   end

   // Next-state for prescaler, counter, event counter and one-shot done flag
   always_comb begin
      w_psc_nxt  = r_psc_cnt;
      w_cnt_nxt  = r_count;
      w_evt_nxt  = r_event;
      w_done_nxt = r_done;
      if (timer_clear) begin
         w_psc_nxt  = {PSC_W{1'b0}};
         w_cnt_nxt  = {CNT_W{1'b0}};
         w_evt_nxt  = {EVT_W{1'b0}};
         w_done_nxt = 1'b0;
      end else if (!timer_enable) begin
         // Frozen: psc_cnt is kept so the period resumes exactly where it stopped
         w_psc_nxt  = r_psc_cnt;
         w_cnt_nxt  = r_count;
         w_evt_nxt  = r_event;
         w_done_nxt = r_done;
      end else begin
         // The prescaler keeps running even after a one-shot has finished
         if (w_tick) begin
            w_psc_nxt = {PSC_W{1'b0}};
         end else begin
            w_psc_nxt = r_psc_cnt + PSC_W'(1);
         end

         if (!w_tick) begin
            w_cnt_nxt = r_count;
         end else if (timer_mode) begin
            // Periodic: any tick releases a finished one-shot and resumes counting
            w_done_nxt = 1'b0;
            if (w_at_term) begin
               w_cnt_nxt = {CNT_W{1'b0}};
               w_evt_nxt = r_event + EVT_W'(1);
            end else begin
               w_cnt_nxt = r_count + CNT_W'(1);
            end
         end else if (r_done) begin
            // One-shot finished: nothing changes until clear or reset
            w_cnt_nxt = r_count;
         end else if (w_at_term) begin
            // One-shot termination: count holds at its value
            w_done_nxt = 1'b1;
            w_evt_nxt  = r_event + EVT_W'(1);
         end else begin
            w_cnt_nxt = r_count + CNT_W'(1);
         end
      end
   end

`ifdef TIMER_IRQ_STICKY_EN
   // Sticky interrupt flag: set on an event, held while frozen, clear wins over set
   always_comb begin
      w_irq_nxt = r_irq;
      if (timer_clear) begin
         w_irq_nxt = 1'b0;
      end else if (w_fire) begin
         w_irq_nxt = 1'b1;
      end else begin
         w_irq_nxt = r_irq;
      end
   end
`else
   // Pulse interrupt: high for exactly the cycle after each event
   always_comb begin
      w_irq_nxt = 1'b0;
      if (timer_clear || !timer_enable) begin
         w_irq_nxt = 1'b0;
      end else begin
         w_irq_nxt = w_fire;
      end
   end
`endif

   // State register update with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_psc_cnt <= {PSC_W{1'b0}};
         r_count   <= {CNT_W{1'b0}};
         r_event   <= {EVT_W{1'b0}};
         r_done    <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_psc_cnt <= w_psc_nxt;
         r_count   <= w_cnt_nxt;
         r_event   <= w_evt_nxt;
         r_done    <= w_done_nxt;
         r_irq     <= w_irq_nxt;
      end
   end

   assign timer_event     = r_event;
   assign timer_count     = r_count;
   assign timer_interrupt = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_timer.sv
//------------------------------------------------------------------------------
// tb_timer
//------------------------------------------------------------------------------
// Self-checking bench for timer. The reference model tracks only the number of
// enabled clocks since the last clear/reset and derives count, event total and
// interrupt arithmetically from it; a negedge process compares every cycle.
// Directed scenarios add hand-computed literal expectations.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_timer;

   localparam int PSC_W = 8;
   localparam int CNT_W = 32;
   localparam int EVT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [PSC_W-1:0] prescaler = '0;
   logic [CNT_W-1:0] autoreload = '0;
   logic             timer_clear = 1'b0;
   logic             timer_enable = 1'b0;
   logic             timer_mode = 1'b0;
   logic [EVT_W-1:0] timer_event;
   logic [CNT_W-1:0] timer_count;
   logic             timer_interrupt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   timer #(.PSC_W(PSC_W), .CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .prescaler       (prescaler),
      .autoreload      (autoreload),
      .timer_clear     (timer_clear),
      .timer_enable    (timer_enable),
      .timer_mode      (timer_mode),
      .timer_event     (timer_event),
      .timer_count     (timer_count),
      .timer_interrupt (timer_interrupt)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint f_ticks(input longint n, input longint p);
      return n / (p + 1);
   endfunction

   function automatic longint f_events(input longint n, input longint p,
                                       input longint ar, input logic mode);
      longint t;
      t = f_ticks(n, p);
      if (mode) return t / (ar + 1);
      else      return (t > ar) ? 64'd1 : 64'd0;
   endfunction

   function automatic longint f_count(input longint n, input longint p,
                                      input longint ar, input logic mode);
      longint t;
      t = f_ticks(n, p);
      if (mode) return t % (ar + 1);
      else      return (t < ar) ? t : ar;
   endfunction

   longint m_n    = 0;
   logic   m_irq  = 1'b0;
   longint m_p    = 0;
   longint m_ar   = 0;
   logic   m_mode = 1'b0;

   // Model state: enabled clocks since clear plus the edge-sampled configuration
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_n   <= 0;
         m_irq <= 1'b0;
      end else begin
         m_p    <= longint'(prescaler);
         m_ar   <= longint'(autoreload);
         m_mode <= timer_mode;
         if (timer_clear) begin
            m_n   <= 0;
            m_irq <= 1'b0;
         end else if (!timer_enable) begin
`ifdef TIMER_IRQ_STICKY_EN
            m_irq <= m_irq;
`else
            m_irq <= 1'b0;
`endif
         end else begin
            m_n <= m_n + 1;
`ifdef TIMER_IRQ_STICKY_EN
            m_irq <= m_irq |
                     (f_events(m_n + 1, longint'(prescaler), longint'(autoreload), timer_mode) >
                      f_events(m_n,     longint'(prescaler), longint'(autoreload), timer_mode));
`else
            m_irq <= (f_events(m_n + 1, longint'(prescaler), longint'(autoreload), timer_mode) >
                      f_events(m_n,     longint'(prescaler), longint'(autoreload), timer_mode));
`endif
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         check("model_count", longint'(timer_count), f_count(m_n, m_p, m_ar, m_mode));
         check("model_event", longint'(timer_event),
               f_events(m_n, m_p, m_ar, m_mode) % 65536);
         check("model_irq", longint'(timer_interrupt), longint'(m_irq));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic restart(input int p, input int ar, input logic mode);
      timer_enable = 1'b0;
      timer_clear  = 1'b1;
      prescaler    = PSC_W'(p);
      autoreload   = CNT_W'(ar);
      timer_mode   = mode;
      step();
      timer_clear  = 1'b0;
      timer_enable = 1'b1;
   endtask

   int exp1 [12] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
   int irq_n;
   int first_irq;

   initial begin
      // Reset state
      #12;
      check("reset_count", longint'(timer_count), 0);
      check("reset_event", longint'(timer_event), 0);
      check("reset_irq", longint'(timer_interrupt), 0);
      step();
      rst = 1'b1;

      // Periodic, prescaler 0, autoreload 3
      restart(0, 3, 1'b1);
      for (int i = 0; i < 12; i++) begin
         step();
         check("t1_count", longint'(timer_count), exp1[i]);
`ifdef TIMER_IRQ_STICKY_EN
         check("t1_irq", longint'(timer_interrupt), (i >= 3) ? 1 : 0);
`else
         check("t1_irq", longint'(timer_interrupt), (i % 4 == 3) ? 1 : 0);
`endif
      end
      check("t1_event", longint'(timer_event), 3);

      // Periodic, prescaler 10, autoreload 100, 5000 clocks
      restart(10, 100, 1'b1);
      irq_n = 0;
      for (int i = 0; i < 5000; i++) begin
         step();
         if (timer_interrupt) irq_n++;
         if (i == 9)  check("t2_count_pre", longint'(timer_count), 0);
         if (i == 10) check("t2_count_tick", longint'(timer_count), 1);
         if (i == 21) check("t2_count_tick2", longint'(timer_count), 2);
      end
      check("t2_event", longint'(timer_event), 4);
      check("t2_count", longint'(timer_count), 50);
`ifndef TIMER_IRQ_STICKY_EN
      check("t2_irq_pulses", longint'(irq_n), 4);
`endif
      timer_clear = 1'b1;
      step();
      timer_clear = 1'b0;
      check("t2_clr_count", longint'(timer_count), 0);
      check("t2_clr_event", longint'(timer_event), 0);

      // One-shot, prescaler 2, autoreload 5
      restart(2, 5, 1'b0);
      irq_n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (timer_interrupt) irq_n++;
         if (i == 14) begin
            check("t3_count15", longint'(timer_count), 5);
            check("t3_event15", longint'(timer_event), 0);
         end
         if (i == 17) check("t3_event18", longint'(timer_event), 1);
      end
      check("t3_count_hold", longint'(timer_count), 5);
      check("t3_event_hold", longint'(timer_event), 1);
`ifndef TIMER_IRQ_STICKY_EN
      check("t3_irq_pulses", longint'(irq_n), 1);
`endif
      timer_clear = 1'b1;
      step();
      timer_clear = 1'b0;
      check("t3_clr_count", longint'(timer_count), 0);
      check("t3_clr_event", longint'(timer_event), 0);
      step(); step(); step();
      check("t3_restart_count", longint'(timer_count), 1);

      // Freeze mid-period for 20 clocks: first interrupt moves from 32 to 52
      restart(3, 7, 1'b1);
      first_irq = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (timer_interrupt && first_irq == 0) first_irq = k;
         if (k == 10) timer_enable = 1'b0;
         if (k == 30) begin
            check("t4_frozen_count", longint'(timer_count), 2);
            check("t4_frozen_event", longint'(timer_event), 0);
            timer_enable = 1'b1;
         end
      end
      check("t4_first_irq", longint'(first_irq), 52);

      // Clear in the exact cycle of the terminal tick
      restart(0, 3, 1'b1);
      step(); step(); step();
      check("t5_count_pre", longint'(timer_count), 3);
      timer_clear = 1'b1;
      step();
      timer_clear = 1'b0;
      check("t5_count", longint'(timer_count), 0);
      check("t5_event", longint'(timer_event), 0);
      check("t5_irq", longint'(timer_interrupt), 0);

      // Asynchronous reset mid-count
      restart(0, 3, 1'b1);
      for (int i = 0; i < 6; i++) step();
      check("t6_pre_event", longint'(timer_event), 1);
      #1;
      rst = 1'b0;
      #1;
      check("t6_rst_count", longint'(timer_count), 0);
      check("t6_rst_event", longint'(timer_event), 0);
      check("t6_rst_irq", longint'(timer_interrupt), 0);
      step();
      rst = 1'b1;
      step(); step();
      check("t6_restart_count", longint'(timer_count), 2);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
